// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully connected layer scheduler.
//   fc_state_e : scheduler FSM states
//   fc_flat()  : flattened input length (size * size * channels)
//   fc_acc_w() : accumulator width that cannot overflow for a given length
//   sat_px()   : clamp a signed value into a px_size-bit two's complement range
package fc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StDrain = 3'd2,
        StBias  = 3'd3,
        StOut   = 3'd4,
        StDone  = 3'd5
    } fc_state_e;

    function automatic int unsigned fc_flat(input int unsigned size, input int unsigned chans);
        return size * size * chans;
    endfunction

    // Full product width plus one growth bit per doubling of the term count,
    // plus a spare bit for the bias term.
    function automatic int unsigned fc_acc_w(input int unsigned px_size,
                                             input int unsigned flat);
        return 2 * px_size + $clog2(flat) + 1;
    endfunction

    // Shared with the other fixed-point layers; callers narrow the result
    // back to px_size bits with a size cast.
    function automatic logic signed [63:0] sat_px(input logic signed [63:0] v,
                                                  input int unsigned       px_size);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (px_size - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (px_size - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed multiply-accumulate with bias add, fixed-point rescale and
// saturation for one output channel at a time.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous accumulator clear (wins over i_en)
//   i_en     : add i_px * i_w to the accumulator this edge
//   i_px     : signed input pixel
//   i_w      : signed weight
//   i_bias   : signed bias, same fixed-point format as pixels
//   o_res    : saturated ((acc + bias << FRAC_BITS) >>> FRAC_BITS), combinational
module fc_mac
    import fc_pkg::*;
#(
    parameter int unsigned PX_SIZE   = 8,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned ACC_W     = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic signed [PX_SIZE-1:0] i_px,
    input  logic signed [PX_SIZE-1:0] i_w,
    input  logic signed [PX_SIZE-1:0] i_bias,
    output logic signed [PX_SIZE-1:0] o_res
);

    logic signed [2*PX_SIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]     w_bias_sh;
    logic signed [ACC_W-1:0]     w_sum;
    logic signed [ACC_W-1:0]     w_shift;
    logic signed [ACC_W-1:0]     r_acc;

    assign w_prod    = i_px * i_w;

    // Product of two Qx.FRAC values carries 2*FRAC fractional bits, so the
    // bias is aligned by shifting it up FRAC bits before the common rescale.
    assign w_bias_sh = ACC_W'(i_bias) <<< FRAC_BITS;
    assign w_sum     = r_acc + w_bias_sh;

    // Arithmetic shift: rounds toward minus infinity.
    assign w_shift   = w_sum >>> FRAC_BITS;
    assign o_res     = PX_SIZE'(sat_px(64'(w_shift), PX_SIZE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

endmodule

// File: rtl/fc_sched.sv
// fc_sched: sequential fully connected layer. One MAC is time-multiplexed
// over all output channels; each channel streams the flattened input and its
// weight row from external synchronous RAMs, adds its bias, rescales,
// saturates and is handed downstream on a valid/ready port.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a layer evaluation (only looked at while idle)
//   busy          : high whenever the FSM is not idle
//   done          : one-cycle pulse after the last channel handshake
//   in_addr       : flat input index, (x*INPUT_SIZE+y)*INPUT_CHANNELS+ch
//   w_addr        : weight index, c*FLAT + in_addr
//   rd_en         : read strobe shared by input and weight RAMs
//   in_data/w_data: RAM read data, valid the cycle after rd_en
//   b_addr/b_rd_en: bias RAM address and strobe
//   b_data        : bias, valid the cycle after b_rd_en
//   out_valid/out_ready/out_data/out_ch : result handshake port
module fc_sched
    import fc_pkg::*;
#(
    parameter int unsigned INPUT_SIZE      = 5,
    parameter int unsigned INPUT_CHANNELS  = 3,
    parameter int unsigned OUTPUT_CHANNELS = 3,
    parameter int unsigned PX_SIZE         = 8,
    parameter int unsigned FRAC_BITS       = 4,
    localparam int unsigned FLAT  = fc_flat(INPUT_SIZE, INPUT_CHANNELS),
    localparam int unsigned ACC_W = fc_acc_w(PX_SIZE, FLAT),
    localparam int unsigned IA_W  = (FLAT > 1) ? $clog2(FLAT) : 1,
    localparam int unsigned WA_W  = (OUTPUT_CHANNELS * FLAT > 1) ?
                                    $clog2(OUTPUT_CHANNELS * FLAT) : 1,
    localparam int unsigned CH_W  = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [IA_W-1:0]    in_addr,
    output logic [WA_W-1:0]    w_addr,
    output logic               rd_en,
    input  logic [PX_SIZE-1:0] in_data,
    input  logic [PX_SIZE-1:0] w_data,
    output logic [CH_W-1:0]    b_addr,
    output logic               b_rd_en,
    input  logic [PX_SIZE-1:0] b_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PX_SIZE-1:0] out_data,
    output logic [CH_W-1:0]    out_ch
);

    localparam logic [IA_W-1:0] LAST_I = IA_W'(FLAT - 1);
    localparam logic [CH_W-1:0] LAST_C = CH_W'(OUTPUT_CHANNELS - 1);
    localparam logic [WA_W-1:0] W_STEP = WA_W'(FLAT);

    fc_state_e          r_state;
    logic [CH_W-1:0]    r_c;
    logic [WA_W-1:0]    r_w_base;
    logic [IA_W-1:0]    r_in_addr;
    logic [WA_W-1:0]    r_w_addr;
    logic               r_rd_en;
    logic               r_rd_dly;
    logic [CH_W-1:0]    r_b_addr;
    logic               r_b_rd_en;
    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic [PX_SIZE-1:0] r_out_data;
    logic [CH_W-1:0]    r_out_ch;

    logic               w_clr;
    logic               w_next_ch;
    logic [PX_SIZE-1:0] w_res;

    // Advancing to another channel from OUT: accept seen and channels remain.
    assign w_next_ch = (r_state == StOut) && out_ready && (r_c != LAST_C);

    // The accumulator is cleared on the edge that enters RUN. The first read
    // of that run is issued on the same edge, so its product is not
    // accumulated until two edges later and never collides with the clear.
    assign w_clr = ((r_state == StIdle) && start) || w_next_ch;

    fc_mac #(
        .PX_SIZE  (PX_SIZE),
        .FRAC_BITS(FRAC_BITS),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (r_rd_dly),
        .i_px  (in_data),
        .i_w   (w_data),
        .i_bias(b_data),
        .o_res (w_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_c         <= '0;
            r_w_base    <= '0;
            r_in_addr   <= '0;
            r_w_addr    <= '0;
            r_rd_en     <= 1'b0;
            r_rd_dly    <= 1'b0;
            r_b_addr    <= '0;
            r_b_rd_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else begin
            // Read data lands one cycle after the strobe; this flag marks it.
            r_rd_dly  <= r_rd_en;
            r_done    <= 1'b0;
            r_b_rd_en <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state   <= StRun;
                        r_busy    <= 1'b1;
                        r_c       <= '0;
                        r_w_base  <= '0;
                        r_in_addr <= '0;
                        r_w_addr  <= '0;
                        r_rd_en   <= 1'b1;
                    end
                end

                StRun: begin
                    if (r_in_addr == LAST_I) begin
                        r_rd_en   <= 1'b0;
                        r_b_rd_en <= 1'b1;
                        r_b_addr  <= r_c;
                        r_state   <= StDrain;
                    end else begin
                        r_in_addr <= r_in_addr + IA_W'(1);
                        r_w_addr  <= r_w_addr + WA_W'(1);
                    end
                end

                // Last product is accumulated on this edge; bias data arrives.
                StDrain: begin
                    r_state <= StBias;
                end

                StBias: begin
                    r_out_data  <= w_res;
                    r_out_ch    <= r_c;
                    r_out_valid <= 1'b1;
                    r_state     <= StOut;
                end

                StOut: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_c == LAST_C) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_c       <= r_c + CH_W'(1);
                            r_w_base  <= r_w_base + W_STEP;
                            r_w_addr  <= r_w_base + W_STEP;
                            r_in_addr <= '0;
                            r_rd_en   <= 1'b1;
                            r_state   <= StRun;
                        end
                    end
                end

                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_addr   = r_in_addr;
    assign w_addr    = r_w_addr;
    assign rd_en     = r_rd_en;
    assign b_addr    = r_b_addr;
    assign b_rd_en   = r_b_rd_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_fc_sched.sv
// tb_fc_sched: self-checking bench for fc_sched with behavioural input,
// weight and bias RAMs and a queue of expected channel results.
module tb_fc_sched;

    localparam int unsigned INPUT_SIZE = 5;
    localparam int unsigned INPUT_CH   = 3;
    localparam int unsigned OC         = 3;
    localparam int unsigned PX         = 8;
    localparam int unsigned FRAC       = 4;
    localparam int unsigned FLAT       = 75;
    localparam int unsigned IA_W       = 7;
    localparam int unsigned WA_W       = 8;
    localparam int unsigned CH_W       = 2;
    localparam int          PERIOD     = FLAT + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic [IA_W-1:0] in_addr;
    logic [WA_W-1:0] w_addr;
    logic            rd_en;
    logic [PX-1:0]   in_data;
    logic [PX-1:0]   w_data;
    logic [CH_W-1:0] b_addr;
    logic            b_rd_en;
    logic [PX-1:0]   b_data;
    logic            out_valid;
    logic            out_ready;
    logic [PX-1:0]   out_data;
    logic [CH_W-1:0] out_ch;

    logic [31:0]     all_outs;

    logic signed [PX-1:0] in_mem [FLAT];
    logic signed [PX-1:0] w_mem  [OC*FLAT];
    logic signed [PX-1:0] b_mem  [OC];

    typedef struct {
        int            ch;
        logic [PX-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    assign all_outs = {busy, done, rd_en, b_rd_en, out_valid, in_addr, w_addr, b_addr,
                       out_data, out_ch};

    fc_sched #(
        .INPUT_SIZE     (INPUT_SIZE),
        .INPUT_CHANNELS (INPUT_CH),
        .OUTPUT_CHANNELS(OC),
        .PX_SIZE        (PX),
        .FRAC_BITS      (FRAC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in_addr  (in_addr),
        .w_addr   (w_addr),
        .rd_en    (rd_en),
        .in_data  (in_data),
        .w_data   (w_data),
        .b_addr   (b_addr),
        .b_rd_en  (b_rd_en),
        .b_data   (b_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch)
    );

    // Synchronous RAMs: one cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= in_mem[in_addr];
            w_data  <= w_mem[w_addr];
        end
        if (b_rd_en) begin
            b_data <= b_mem[b_addr];
        end
    end

    function automatic int ref_px(input int k);
        int sum;
        int r;
        sum = 0;
        for (int i = 0; i < FLAT; i++) begin
            sum += int'(in_mem[i]) * int'(w_mem[k*FLAT + i]);
        end
        sum += int'(b_mem[k]) * (1 << FRAC);
        r = sum >>> FRAC;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic fill_const(input int px_v, input int w_v, input int b_v);
        for (int i = 0; i < FLAT; i++) in_mem[i] = PX'(px_v);
        for (int i = 0; i < OC*FLAT; i++) w_mem[i] = PX'(w_v);
        for (int i = 0; i < OC; i++) b_mem[i] = PX'(b_v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < FLAT; i++) in_mem[i] = PX'(int'($urandom_range(40)) - 20);
        for (int i = 0; i < OC*FLAT; i++) w_mem[i] = PX'(int'($urandom_range(40)) - 20);
        for (int i = 0; i < OC; i++) b_mem[i] = PX'(int'($urandom_range(16)) - 8);
    endtask

    // Starts one layer (called at a negedge) and walks it cycle by cycle.
    // cyc N is the interval just before edge N, where edge 0 samples start.
    task automatic run_layer(input int stall_ch, input int stall_len, input int repulse_cyc);
        int            cyc;
        int            n_done;
        int            stall_left;
        bit            stall_armed;
        int            exp_done;
        logic [PX-1:0] held_data;
        logic [CH_W-1:0] held_ch;
        exp_t          e;
        n_done      = 0;
        stall_left  = 0;
        stall_armed = (stall_len > 0);
        held_data   = '0;
        held_ch     = '0;
        for (int k = 0; k < OC; k++) begin
            e.ch   = k;
            e.data = PX'(ref_px(k));
            e.cyc  = (k + 1) * PERIOD + ((stall_len > 0 && k >= stall_ch) ? stall_len : 0);
            exp_q.push_back(e);
        end
        exp_done = OC * PERIOD + 1 + stall_len;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc <= exp_done + 1) begin
            start = (cyc == repulse_cyc);
            if (cyc == 5) begin
                n_checks++;
                if (busy !== 1'b1 || rd_en !== 1'b1 || b_rd_en !== 1'b0 || in_addr !== 7'd4
                    || w_addr !== 8'd4) begin
                    n_errors++;
                    $display("FAIL run_ch0 cyc=%0d: busy=%b rd_en=%b b_rd_en=%b in_addr=%0d w_addr=%0d, required 1 1 0 4 4",
                             cyc, busy, rd_en, b_rd_en, in_addr, w_addr);
                end
            end
            if (cyc == FLAT + 1) begin
                n_checks++;
                if (rd_en !== 1'b0 || b_rd_en !== 1'b1 || b_addr !== 2'd0) begin
                    n_errors++;
                    $display("FAIL drain cyc=%0d: rd_en=%b b_rd_en=%b b_addr=%0d, required 0 1 0",
                             cyc, rd_en, b_rd_en, b_addr);
                end
            end
            if (cyc == PERIOD + 5) begin
                n_checks++;
                if (rd_en !== 1'b1 || in_addr !== 7'd4 || w_addr !== WA_W'(FLAT + 4)) begin
                    n_errors++;
                    $display("FAIL run_ch1 cyc=%0d: rd_en=%b in_addr=%0d w_addr=%0d, required 1 4 %0d",
                             cyc, rd_en, in_addr, w_addr, FLAT + 4);
                end
            end
            if (stall_armed && out_valid === 1'b1 && out_ch == CH_W'(stall_ch)) begin
                stall_armed = 1'b0;
                stall_left  = stall_len;
                held_data   = out_data;
                held_ch     = out_ch;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_ch !== held_ch
                    || rd_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_hold cyc=%0d: valid=%b data=%0d ch=%0d rd_en=%b, required 1 %0d %0d 0",
                             cyc, out_valid, out_data, out_ch, rd_en, held_data, held_ch);
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_output cyc=%0d: ch=%0d data=%0d, required no output",
                             cyc, out_ch, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_ch !== CH_W'(e.ch) || out_data !== e.data || cyc != e.cyc) begin
                        n_errors++;
                        $display("FAIL result: ch=%0d data=%0d cyc=%0d, required ch=%0d data=%0d cyc=%0d",
                                 out_ch, $signed(out_data), cyc, e.ch, $signed(e.data), e.cyc);
                    end
                end
            end
            if (done !== 1'b0) begin
                n_done++;
                n_checks++;
                if (cyc != exp_done) begin
                    n_errors++;
                    $display("FAIL done_cycle: done at %0d, required %0d", cyc, exp_done);
                end
            end
            if (cyc == exp_done + 1) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL busy_after_done cyc=%0d: busy=%b, required 0", cyc, busy);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (n_done != 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL layer_count: done pulses=%0d missing outputs=%0d, required 1 and 0",
                     n_done, exp_q.size());
        end
        exp_q.delete();
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, rd_en, b_rd_en, out_valid} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy/done/rd/b_rd/valid=%b, required 00000",
                     {busy, done, rd_en, b_rd_en, out_valid});
        end
        n_checks++;
        if (in_addr !== '0 || w_addr !== '0 || b_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_addr: in=%0d w=%0d b=%0d, required 0 0 0", in_addr, w_addr, b_addr);
        end
        n_checks++;
        if (out_data !== '0 || out_ch !== '0) begin
            n_errors++;
            $display("FAIL reset_out: data=%0d ch=%0d, required 0 0", out_data, out_ch);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset: outs=%h, required 0", all_outs);
        end
    endtask

    task automatic test_basic();
        fill_const(16, 1, 0);
        run_layer(-1, 0, 0);
    endtask

    task automatic test_saturation();
        fill_const(127, 127, 0);
        run_layer(-1, 0, 0);
        fill_const(127, -128, 0);
        run_layer(-1, 0, 0);
    endtask

    task automatic test_bias();
        fill_const(0, 5, 0);
        b_mem[0] = 8'sd1;
        b_mem[1] = -8'sd2;
        b_mem[2] = 8'sd3;
        run_layer(-1, 0, 0);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_layer(1, 5, 0);
    endtask

    task automatic test_abort();
        int cyc;
        int stray;
        fill_const(16, 1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_errors++;
            $display("FAIL abort_immediate: outs=%h, required 0", all_outs);
        end
        @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin
            n_errors++;
            $display("FAIL abort_next_cycle: outs=%h, required 0", all_outs);
        end
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++;
            $display("FAIL abort_quiet: active cycles=%0d, required 0", stray);
        end
        fill_random();
        run_layer(-1, 0, 0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_layer(-1, 0, 10);
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_layer(-1, 0, 0);
        fill_random();
        run_layer(-1, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        fill_const(0, 0, 0);
        test_reset();
        test_basic();
        test_saturation();
        test_bias();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
